// File: rtl/utmi_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : utmi_tx_serializer
// Brief    : UTMI transmit serializer. Sends SYNC, then DATA_W-bit words
//            LSB-first with bit stuffing, then an SE0/SE0/J end of packet.
//            Define UTMI_TX_NRZI_EN for NRZI line coding; without it the
//            stuffed raw bit stream is driven directly on tx_dout.
// Revision : 1.0
// ============================================================================
module utmi_tx_serializer #(
    parameter int         DATA_W    = 8,
    parameter int         STUFF_LEN = 6,
    parameter logic [7:0] SYNC_PAT  = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_dout,
    output logic              tx_se0,
    output logic              tx_oe,
    output logic              tx_active
);

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [2:0]       STUFF_CNT = 3'(STUFF_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_EOP  = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [2:0]        sync_cnt_q, sync_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [2:0]        ones_q,     ones_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic [1:0]        eop_cnt_q,  eop_cnt_d;
    logic              tx_dout_q,  tx_dout_d;
    logic              tx_se0_q,   tx_se0_d;
    logic              tx_oe_q,    tx_oe_d;

    logic              stuff;
    logic              bit_valid;
    logic              raw_bit;
    logic              line_bit;
    logic              se0_cycle;

    assign stuff = (ones_q == STUFF_CNT);

`ifdef UTMI_TX_NRZI_EN
    // A raw 0 is a transition on the line, a raw 1 keeps the level.
    assign line_bit = raw_bit ? tx_dout_q : ~tx_dout_q;
`else
    assign line_bit = raw_bit;
`endif

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        shift_d    = shift_q;
        eop_cnt_d  = eop_cnt_q;
        tx_ready   = 1'b0;
        bit_valid  = 1'b0;
        raw_bit    = 1'b1;
        se0_cycle  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ones_d     = 3'd0;
                sync_cnt_d = 3'd0;
                bit_cnt_d  = '0;
                eop_cnt_d  = 2'd0;
                if (tx_valid) begin
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                bit_valid = 1'b1;
                if (stuff) begin
                    raw_bit = 1'b0;
                    ones_d  = 3'd0;
                end else begin
                    raw_bit    = SYNC_PAT[sync_cnt_q];
                    ones_d     = raw_bit ? ones_q + 3'd1 : 3'd0;
                    sync_cnt_d = sync_cnt_q + 3'd1;
                    if (sync_cnt_q == 3'd7) begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            shift_d   = tx_data;
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                        end else begin
                            eop_cnt_d = 2'd0;
                            state_d   = ST_EOP;
                        end
                    end
                end
            end

            ST_DATA: begin
                bit_valid = 1'b1;
                if (stuff) begin
                    // Stuff cycle: shifter and bit counter hold, word not consumed.
                    raw_bit = 1'b0;
                    ones_d  = 3'd0;
                end else begin
                    raw_bit   = shift_q[0];
                    ones_d    = raw_bit ? ones_q + 3'd1 : 3'd0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            shift_d   = tx_data;
                            bit_cnt_d = '0;
                        end else begin
                            eop_cnt_d = 2'd0;
                            state_d   = ST_EOP;
                        end
                    end
                end
            end

            ST_EOP: begin
                if (stuff) begin
                    // Trailing run of ones from the last word still owes a stuff bit.
                    bit_valid = 1'b1;
                    raw_bit   = 1'b0;
                    ones_d    = 3'd0;
                end else begin
                    eop_cnt_d = eop_cnt_q + 2'd1;
                    if (eop_cnt_q != 2'd2) begin
                        se0_cycle = 1'b1;
                    end else begin
                        eop_cnt_d = 2'd0;
                        state_d   = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_oe_d   = (state_q != ST_IDLE);
        tx_se0_d  = 1'b0;
        tx_dout_d = 1'b1;
        if (bit_valid) begin
            tx_dout_d = line_bit;
        end else if (se0_cycle) begin
            tx_se0_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sync_cnt_q <= 3'd0;
            bit_cnt_q  <= '0;
            ones_q     <= 3'd0;
            shift_q    <= '0;
            eop_cnt_q  <= 2'd0;
            tx_dout_q  <= 1'b1;
            tx_se0_q   <= 1'b0;
            tx_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            shift_q    <= shift_d;
            eop_cnt_q  <= eop_cnt_d;
            tx_dout_q  <= tx_dout_d;
            tx_se0_q   <= tx_se0_d;
            tx_oe_q    <= tx_oe_d;
        end
    end

    assign tx_dout   = tx_dout_q;
    assign tx_se0    = tx_se0_q;
    assign tx_oe     = tx_oe_q;
    assign tx_active = (state_q != ST_IDLE);

endmodule

`default_nettype wire
